fuel_dispenser: RTL and testbench
=================================

FUEL_DISPENSER -- requirements
Module: fuel_dispenser

Interface
REQ-001 Parameter WIDTH, default 8, bit width of the dispensed-amount counter.
REQ-002 Parameter RATE_DIV, default 1 (legal range >=1), clock cycles per dispensed unit.
REQ-003 Parameter PRICE_W, default 8, bit width of the per-unit price.
REQ-004 clk  input  1  single system clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  level; begin a transaction (IDLE/DONE) or resume one (PAUSED).
REQ-007 stop  input  1  level; pause dispensing.
REQ-008 clear  input  1  level; abort any transaction and zero all counters.
REQ-009 preset  input  WIDTH  target amount, sampled on transaction start; 0 means unlimited.
REQ-010 price  input  PRICE_W  per-unit price, sampled on transaction start.
REQ-011 fuel_amount  output  WIDTH  units dispensed in the current or last transaction.
REQ-012 total_cost  output  WIDTH+PRICE_W  running cost = fuel_amount * latched price.
REQ-013 busy  output  1  high in DISPENSE and PAUSED.
REQ-014 done  output  1  high in DONE.

Function
REQ-015 The FSM SHALL have the states IDLE, DISPENSE, PAUSED and DONE.
REQ-016 Input priority SHALL be reset > clear > stop > start; when stop and start are asserted together, stop wins.
REQ-017 clear SHALL, from any state, go to IDLE next cycle and zero fuel_amount, total_cost and the prescaler.
REQ-018 IDLE or DONE with start SHALL go to DISPENSE, zero fuel_amount, total_cost and the prescaler, and latch preset and price.
REQ-019 In DISPENSE the prescaler SHALL count 0..RATE_DIV-1; on the cycle it equals RATE_DIV-1 it SHALL wrap to 0, fuel_amount SHALL increment by 1, and total_cost SHALL increase by the latched price.
REQ-020 The first increment SHALL occur RATE_DIV cycles after the DISPENSE entry edge.
REQ-021 With a nonzero latched preset, the increment that makes fuel_amount equal to the preset SHALL also move the FSM to DONE on the same edge.
REQ-022 With a latched preset of 0, the increment that makes fuel_amount equal to all-ones SHALL move the FSM to DONE; fuel_amount SHALL never wrap.
REQ-023 DISPENSE with stop SHALL go to PAUSED; fuel_amount, total_cost and the prescaler SHALL hold, and no increment SHALL occur on that edge.
REQ-024 PAUSED with start and without stop SHALL return to DISPENSE, and the prescaler SHALL continue from its held value.
REQ-025 In DONE, fuel_amount and total_cost SHALL hold until clear or start; stop SHALL have no effect.
REQ-026 In IDLE without start, all outputs SHALL hold.
REQ-027 busy and done SHALL be registered decodes of the state, with no combinational path from inputs.
REQ-028 total_cost SHALL be computed by accumulation, with no multiplier, and SHALL equal fuel_amount*price exactly.

Reset
REQ-029 reset SHALL, at the next rising clk edge, set the state to IDLE.
REQ-030 reset SHALL set fuel_amount=0, total_cost=0, busy=0, done=0, and zero the prescaler, latched preset and latched price.
REQ-031 reset asserted during DISPENSE or PAUSED SHALL discard the transaction; no increment SHALL occur on the reset edge.

Structure
REQ-032 The state enum type fuel_state_t SHALL reside in a shared package fuel_pkg.
REQ-033 The default parameter constants SHALL also reside in fuel_pkg.
REQ-034 The prescaler SHALL be one sub-module, rate_prescaler, with ports clk, reset, en, clr, tick and parameter RATE_DIV.
REQ-035 rate_prescaler SHALL emit tick for one cycle when it wraps and SHALL hold its count when en is low.

Verification
REQ-036 Setup reset, RATE_DIV=1, preset=5, price=3; stimulus start pulse -> fuel_amount reads 1..5 on successive cycles, done=1 with fuel_amount=5 and total_cost=15, busy=0.
REQ-037 Setup RATE_DIV=4, preset=0; stimulus start held -> increments every 4 cycles; fuel_amount stops at 255 in DONE with no wrap.
REQ-038 Setup RATE_DIV=4; stimulus stop mid-count after 2 prescaler cycles, hold 10 cycles, then start -> amount frozen while paused; next increment 2 cycles after resume.
REQ-039 Stimulus start and stop asserted together in DISPENSE -> enters PAUSED; stop is ignored in DONE.
REQ-040 Stimulus clear during DISPENSE at amount 3 -> IDLE with all counters 0 next cycle; subsequent start with preset=2 -> DONE at 2.
REQ-041 Stimulus reset asserted at amount 7 in DISPENSE -> all outputs 0 and state IDLE after the edge; no increment on that edge.

Source files
------------

// File: rtl/fuel_pkg.sv
// Shared types and default parameters for the fuel dispenser.
// The state encoding is used by the top FSM.
package fuel_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_RATE_DIV = 1;
  localparam int DEF_PRICE_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_PAUSED   = 2'd2,
    ST_DONE     = 2'd3
  } fuel_state_t;

endpackage

// File: rtl/rate_prescaler.sv
// Divides the clock into one dispense tick every RATE_DIV enabled cycles.
// The count holds while en is low, so a paused transaction resumes mid-period.
module rate_prescaler #(
  parameter int RATE_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATE_DIV - 1);

  logic [CW-1:0] count_r;

  // tick fires on the wrap cycle only while counting is enabled
  always_comb begin
    tick = 1'b0;
    if (en && (count_r == LAST)) begin
      tick = 1'b1;
    end else begin
      tick = 1'b0;
    end
  end

  // prescaler count: reset/clr zero it, en advances and wraps, otherwise hold
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else if (clr) begin
      count_r <= {CW{1'b0}};
    end else if (en) begin
      if (count_r == LAST) begin
        count_r <= {CW{1'b0}};
      end else begin
        count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/fuel_dispenser.sv
// Fuel dispenser: counts dispensed units at a divided rate and accumulates cost.
// Stops at the latched preset, or at full scale when the preset is zero.
module fuel_dispenser
  import fuel_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int RATE_DIV = DEF_RATE_DIV,
  parameter int PRICE_W  = DEF_PRICE_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           preset,
  input  logic [PRICE_W-1:0]         price,
  output logic [WIDTH-1:0]           fuel_amount,
  output logic [WIDTH+PRICE_W-1:0]   total_cost,
  output logic                       busy,
  output logic                       done
);

  fuel_state_t                 state_r;
  logic [WIDTH-1:0]            preset_r;
  logic [PRICE_W-1:0]          price_r;
  logic [WIDTH-1:0]            amount_r;
  logic [WIDTH+PRICE_W-1:0]    cost_r;
  logic                        busy_r;
  logic                        done_r;

  logic                        ps_en_s;
  logic                        ps_clr_s;
  logic                        ps_tick_s;
  logic [WIDTH-1:0]            next_amount_s;
  logic                        limit_hit_s;

  rate_prescaler #(.RATE_DIV(RATE_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ps_en_s),
    .clr   (ps_clr_s),
    .tick  (ps_tick_s)
  );

  // prescaler control and end-of-transaction detection
  always_comb begin
    ps_en_s       = 1'b0;
    ps_clr_s      = 1'b0;
    next_amount_s = amount_r + {{(WIDTH-1){1'b0}}, 1'b1};
    limit_hit_s   = 1'b0;
    if (clear) begin
      ps_clr_s = 1'b1;
    end else if (((state_r == ST_IDLE) || (state_r == ST_DONE)) && start) begin
      ps_clr_s = 1'b1;
    end else begin
      ps_clr_s = 1'b0;
    end
    if (!clear && !stop && (state_r == ST_DISPENSE)) begin
      ps_en_s = 1'b1;
    end else begin
      ps_en_s = 1'b0;
    end
    if (preset_r != {WIDTH{1'b0}}) begin
      limit_hit_s = (next_amount_s == preset_r);
    end else begin
      limit_hit_s = (next_amount_s == {WIDTH{1'b1}});
    end
  end

  // transaction FSM with registered counters and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      preset_r <= {WIDTH{1'b0}};
      price_r  <= {PRICE_W{1'b0}};
      amount_r <= {WIDTH{1'b0}};
      cost_r   <= {(WIDTH+PRICE_W){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (clear) begin
      state_r  <= ST_IDLE;
      amount_r <= {WIDTH{1'b0}};
      cost_r   <= {(WIDTH+PRICE_W){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r  <= ST_DISPENSE;
            preset_r <= preset;
            price_r  <= price;
            amount_r <= {WIDTH{1'b0}};
            cost_r   <= {(WIDTH+PRICE_W){1'b0}};
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
          end
        end
        ST_DISPENSE: begin
          if (stop) begin
            state_r <= ST_PAUSED;
          end else if (ps_tick_s) begin
            amount_r <= next_amount_s;
            cost_r   <= cost_r + {{WIDTH{1'b0}}, price_r};
            if (limit_hit_s) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (start && !stop) begin
            state_r <= ST_DISPENSE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign fuel_amount = amount_r;
  assign total_cost  = cost_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_fuel_dispenser.sv
// Self-checking bench: two dispensers (RATE_DIV 1 and 4) share stimulus and are
// compared against a model that derives amount from elapsed dispensing cycles.
module tb_fuel_dispenser;

  logic clk = 1'b0;
  logic reset, start, stop, clear;
  logic [7:0] preset, price;
  logic [7:0]  a1, a4;
  logic [15:0] c1, c4;
  logic b1, b4, d1, d4;

  int n_tests = 0;
  int n_fail  = 0;

  // model: 0 idle, 1 running, 2 paused, 3 finished
  int m_mode[2];
  int m_cyc[2];
  int m_pre[2];
  int m_pri[2];

  always #5 clk = ~clk;

  fuel_dispenser #(.WIDTH(8), .RATE_DIV(1), .PRICE_W(8)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .preset(preset), .price(price), .fuel_amount(a1), .total_cost(c1),
    .busy(b1), .done(d1));

  fuel_dispenser #(.WIDTH(8), .RATE_DIV(4), .PRICE_W(8)) dut4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .preset(preset), .price(price), .fuel_amount(a4), .total_cost(c4),
    .busy(b4), .done(d4));

  function automatic int rdv(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [25:0] exp_vec(int k);
    int amt, cost;
    logic [7:0] a8;
    logic [15:0] c16;
    amt  = m_cyc[k] / rdv(k);
    cost = amt * m_pri[k];
    a8   = amt[7:0];
    c16  = cost[15:0];
    return {a8, c16, (m_mode[k] == 1 || m_mode[k] == 2), (m_mode[k] == 3)};
  endfunction

  function automatic logic [25:0] act_vec(int k);
    return (k == 0) ? {a1, c1, b1, d1} : {a4, c4, b4, d4};
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_mode[k] = 0; m_cyc[k] = 0; m_pre[k] = 0; m_pri[k] = 0;
      end else if (clear) begin
        m_mode[k] = 0; m_cyc[k] = 0;
      end else if (m_mode[k] == 0 || m_mode[k] == 3) begin
        if (start) begin
          m_mode[k] = 1; m_cyc[k] = 0; m_pre[k] = preset; m_pri[k] = price;
        end
      end else if (m_mode[k] == 1) begin
        if (stop) m_mode[k] = 2;
        else begin
          m_cyc[k]++;
          if (m_cyc[k] / rdv(k) == ((m_pre[k] != 0) ? m_pre[k] : 255)) m_mode[k] = 3;
        end
      end else if (start && !stop) begin
        m_mode[k] = 1;
      end
    end
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; preset = 8'd0; price = 8'd0;
    tick_cycle();
    tick_cycle();
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (act_vec(k) !== 26'd0) begin
        n_fail++; $display("FAIL reset_state dut%0d got %h exp %h", k, act_vec(k), 26'd0);
      end
    end
    reset = 1'b0;
    tick_cycle();
  endtask

  task automatic test_basic();
    idle_inputs();
    clear = 1'b1; tick_cycle(); clear = 1'b0;
    preset = 8'd5; price = 8'd3; start = 1'b1;
    tick_cycle();
    start = 1'b0;
    n_tests++;
    if (a1 !== 8'd0 || b1 !== 1'b1) begin
      n_fail++; $display("FAIL basic_entry got amt=%0d busy=%b exp amt=0 busy=1", a1, b1);
    end
    for (int i = 1; i <= 5; i++) begin
      tick_cycle();
      n_tests++;
      if (a1 !== 8'(i)) begin
        n_fail++; $display("FAIL basic_count got %0d exp %0d", a1, i);
      end
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (act_vec(k) !== exp_vec(k)) begin
          n_fail++; $display("FAIL basic_model dut%0d got %h exp %h", k, act_vec(k), exp_vec(k));
        end
      end
    end
    n_tests++;
    if (d1 !== 1'b1 || b1 !== 1'b0 || c1 !== 16'd15 || a1 !== 8'd5) begin
      n_fail++; $display("FAIL basic_done got done=%b busy=%b cost=%0d amt=%0d exp 1 0 15 5", d1, b1, c1, a1);
    end
  endtask

  task automatic test_unlimited();
    logic [7:0] p;
    idle_inputs();
    clear = 1'b1; tick_cycle(); clear = 1'b0;
    p = 8'($urandom_range(1, 255));
    preset = 8'd0; price = p; start = 1'b1;
    tick_cycle();
    for (int i = 1; i <= 1030; i++) begin
      if (i == 8) start = 1'b0;
      tick_cycle();
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (act_vec(k) !== exp_vec(k)) begin
          n_fail++; $display("FAIL unlimited_model dut%0d cyc %0d got %h exp %h", k, i, act_vec(k), exp_vec(k));
        end
      end
      if (i == 4 || i == 7) begin
        n_tests++;
        if (a4 !== 8'd1) begin
          n_fail++; $display("FAIL unlimited_rate cyc %0d got %0d exp 1", i, a4);
        end
      end
    end
    n_tests++;
    if (a4 !== 8'd255 || d4 !== 1'b1 || c4 !== 16'd255 * {8'd0, p} || a1 !== 8'd255) begin
      n_fail++; $display("FAIL unlimited_final got amt=%0d done=%b cost=%0d amt1=%0d exp 255 1 %0d 255", a4, d4, c4, a1, 255 * p);
    end
  endtask

  task automatic test_pause();
    idle_inputs();
    clear = 1'b1; tick_cycle(); clear = 1'b0;
    preset = 8'd0; price = 8'd9; start = 1'b1;
    tick_cycle();
    start = 1'b0;
    tick_cycle(); tick_cycle();
    stop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick_cycle();
      n_tests++;
      if (a4 !== 8'd0 || b4 !== 1'b1 || a1 !== 8'd2) begin
        n_fail++; $display("FAIL pause_hold got amt4=%0d busy4=%b amt1=%0d exp 0 1 2", a4, b4, a1);
      end
    end
    stop = 1'b0; start = 1'b1;
    tick_cycle();
    start = 1'b0;
    tick_cycle();
    n_tests++;
    if (a4 !== 8'd0) begin
      n_fail++; $display("FAIL pause_resume1 got %0d exp 0", a4);
    end
    tick_cycle();
    n_tests++;
    if (a4 !== 8'd1 || c4 !== 16'd9) begin
      n_fail++; $display("FAIL pause_resume2 got amt=%0d cost=%0d exp 1 9", a4, c4);
    end
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (act_vec(k) !== exp_vec(k)) begin
        n_fail++; $display("FAIL pause_model dut%0d got %h exp %h", k, act_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_start_stop();
    logic [7:0] held;
    idle_inputs();
    clear = 1'b1; tick_cycle(); clear = 1'b0;
    preset = 8'd3; price = 8'd7; start = 1'b1;
    tick_cycle();
    start = 1'b0;
    tick_cycle();
    start = 1'b1; stop = 1'b1;
    tick_cycle();
    held = a1;
    tick_cycle();
    n_tests++;
    if (a1 !== held || a1 !== 8'd1 || b1 !== 1'b1 || d1 !== 1'b0) begin
      n_fail++; $display("FAIL startstop_pause got amt=%0d busy=%b done=%b exp 1 1 0", a1, b1, d1);
    end
    stop = 1'b0;
    tick_cycle();
    start = 1'b0;
    for (int i = 0; i < 16; i++) tick_cycle();
    stop = 1'b1;
    for (int i = 0; i < 3; i++) tick_cycle();
    n_tests++;
    if (d1 !== 1'b1 || d4 !== 1'b1 || a1 !== 8'd3 || a4 !== 8'd3 || c4 !== 16'd21) begin
      n_fail++; $display("FAIL startstop_done got d1=%b d4=%b a1=%0d a4=%0d c4=%0d exp 1 1 3 3 21", d1, d4, a1, a4, c4);
    end
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (act_vec(k) !== exp_vec(k)) begin
        n_fail++; $display("FAIL startstop_model dut%0d got %h exp %h", k, act_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_clear();
    int n;
    idle_inputs();
    clear = 1'b1; tick_cycle(); clear = 1'b0;
    preset = 8'd0; price = 8'd11; start = 1'b1;
    tick_cycle();
    start = 1'b0;
    n = 0;
    while (a4 !== 8'd3 && n < 50) begin tick_cycle(); n++; end
    n_tests++;
    if (a4 !== 8'd3) begin
      n_fail++; $display("FAIL clear_wait got %0d exp 3", a4);
    end
    clear = 1'b1;
    tick_cycle();
    clear = 1'b0;
    n_tests++;
    if ({a4, c4, b4, d4} !== 26'd0 || {a1, c1, b1, d1} !== 26'd0) begin
      n_fail++; $display("FAIL clear_zero got %h %h exp 0 0", {a4, c4, b4, d4}, {a1, c1, b1, d1});
    end
    preset = 8'd2; start = 1'b1;
    tick_cycle();
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick_cycle();
    n_tests++;
    if (d4 !== 1'b1 || a4 !== 8'd2 || c4 !== 16'd22) begin
      n_fail++; $display("FAIL clear_restart got done=%b amt=%0d cost=%0d exp 1 2 22", d4, a4, c4);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    idle_inputs();
    clear = 1'b1; tick_cycle(); clear = 1'b0;
    preset = 8'd0; price = 8'd5; start = 1'b1;
    tick_cycle();
    start = 1'b0;
    n = 0;
    while (a1 !== 8'd7 && n < 50) begin tick_cycle(); n++; end
    n_tests++;
    if (a1 !== 8'd7) begin
      n_fail++; $display("FAIL resetmid_wait got %0d exp 7", a1);
    end
    reset = 1'b1;
    tick_cycle();
    reset = 1'b0;
    n_tests++;
    if ({a1, c1, b1, d1} !== 26'd0 || {a4, c4, b4, d4} !== 26'd0) begin
      n_fail++; $display("FAIL resetmid_zero got %h %h exp 0 0", {a1, c1, b1, d1}, {a4, c4, b4, d4});
    end
    tick_cycle();
    n_tests++;
    if (a1 !== 8'd0 || b1 !== 1'b0) begin
      n_fail++; $display("FAIL resetmid_idle got amt=%0d busy=%b exp 0 0", a1, b1);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      clear = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 7) == 0);
      start = !stop && ($urandom_range(0, 5) == 0);
      preset = 8'($urandom_range(0, 12));
      price  = 8'($urandom_range(0, 255));
      tick_cycle();
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (act_vec(k) !== exp_vec(k)) begin
          n_fail++; $display("FAIL random_model dut%0d cyc %0d got %h exp %h", k, i, act_vec(k), exp_vec(k));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_cyc[k] = 0; m_pre[k] = 0; m_pri[k] = 0;
    end
    idle_inputs();
    preset = 8'd0; price = 8'd0;
    #1;
    test_reset();
    test_basic();
    test_unlimited();
    test_pause();
    test_start_stop();
    test_clear();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
